// File: rtl/clint_timer_pipe_ctrl.sv
// CLINT mtime/mtimecmp timer and pipeline stall/flush arbiter for the 6-stage RV32 core.
// Optional build macro: CLINT_TIMER_PRESCALE_EN (mtime advances once every TICK_DIV clocks).
module clint_timer_pipe_ctrl #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mtime_addr_i,
  input  logic        mtime_write_valid_i,
  input  logic [31:0] mtime_wdata_i,
  output logic [31:0] mtime_rdata_o,
  output logic        mtime_ge_mtime_o,
  input  logic        compress_stall,
  input  logic        next_stall_preif_i,
  input  logic        ram_stall_valid_if_i,
  input  logic        ram_stall_valid_mem_i,
  input  logic        load_use_valid_id_i,
  input  logic        jump_valid_ex_i,
  input  logic        alu_mul_div_valid_ex_i,
  input  logic        trap_flush_valid_wb_i,
  input  logic        trap_stall_valid_wb_i,
  output logic [5:0]  stall_o,
  output logic [5:0]  flush_o
);

  localparam logic [31:0] ADDR_CMP_LO = CLINT_BASE + 32'h0000_4000;
  localparam logic [31:0] ADDR_CMP_HI = CLINT_BASE + 32'h0000_4004;
  localparam logic [31:0] ADDR_MT_LO  = CLINT_BASE + 32'h0000_BFF8;
  localparam logic [31:0] ADDR_MT_HI  = CLINT_BASE + 32'h0000_BFFC;

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;

  logic sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi, wr_mtime;
  logic tick;

  assign sel_cmp_lo = (mtime_addr_i == ADDR_CMP_LO);
  assign sel_cmp_hi = (mtime_addr_i == ADDR_CMP_HI);
  assign sel_mt_lo  = (mtime_addr_i == ADDR_MT_LO);
  assign sel_mt_hi  = (mtime_addr_i == ADDR_MT_HI);

  assign wr_cmp_lo = mtime_write_valid_i & sel_cmp_lo;
  assign wr_cmp_hi = mtime_write_valid_i & sel_cmp_hi;
  assign wr_mt_lo  = mtime_write_valid_i & sel_mt_lo;
  assign wr_mt_hi  = mtime_write_valid_i & sel_mt_hi;
  assign wr_mtime  = wr_mt_lo | wr_mt_hi;

`ifdef CLINT_TIMER_PRESCALE_EN
  localparam int unsigned DIV = (TICK_DIV == 0) ? 1 : TICK_DIV;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] presc_q;

  assign tick = (presc_q == CW'(DIV - 1));

  // Software writes to mtime restart the prescale phase so the next tick is a full period away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (wr_mtime || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      // A write to either mtime half replaces that cycle's increment, carry included.
      if (wr_mt_lo) begin
        mtime_q[31:0] <= mtime_wdata_i;
      end
      if (wr_mt_hi) begin
        mtime_q[63:32] <= mtime_wdata_i;
      end
      if (!wr_mtime && tick) begin
        mtime_q <= mtime_q + 64'd1;
      end
      if (wr_cmp_lo) begin
        mtimecmp_q[31:0] <= mtime_wdata_i;
      end
      if (wr_cmp_hi) begin
        mtimecmp_q[63:32] <= mtime_wdata_i;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    mtime_rdata_o = '0;
    if (sel_cmp_lo) begin
      mtime_rdata_o = mtimecmp_q[31:0];
    end else if (sel_cmp_hi) begin
      mtime_rdata_o = mtimecmp_q[63:32];
    end else if (sel_mt_lo) begin
      mtime_rdata_o = mtime_q[31:0];
    end else if (sel_mt_hi) begin
      mtime_rdata_o = mtime_q[63:32];
    end
  end

  assign mtime_ge_mtime_o = (mtime_q >= mtimecmp_q);

  // Older stages win: a trap at WB outranks any hazard detected further up the pipe.
  always_comb begin
    stall_o = 6'b000000;
    flush_o = 6'b000000;
    if (!rst) begin
      flush_o = 6'b111111;
    end else if (trap_flush_valid_wb_i) begin
      flush_o = 6'b011111;
    end else if (trap_stall_valid_wb_i) begin
      stall_o = 6'b111111;
    end else if (ram_stall_valid_mem_i) begin
      stall_o = 6'b011111;
      flush_o = 6'b100000;
    end else if (alu_mul_div_valid_ex_i) begin
      stall_o = 6'b001111;
      flush_o = 6'b010000;
    end else if (jump_valid_ex_i) begin
      flush_o = 6'b000110;
    end else if (load_use_valid_id_i) begin
      stall_o = 6'b000111;
      flush_o = 6'b001000;
    end else if (ram_stall_valid_if_i) begin
      stall_o = 6'b000011;
      flush_o = 6'b000100;
    end else if (compress_stall || next_stall_preif_i) begin
      stall_o = 6'b000001;
      flush_o = 6'b000010;
    end
  end

endmodule

// File: tb/tb_clint_timer_pipe_ctrl.sv
// Randomized self-checking bench for clint_timer_pipe_ctrl against a 64-bit arithmetic timer model
// and a table-driven stall/flush priority model (default build, prescaler disabled).
module tb_clint_timer_pipe_ctrl;

  localparam logic [31:0] BASE      = 32'h0200_0000;
  localparam logic [31:0] A_CMP_LO  = BASE + 32'h4000;
  localparam logic [31:0] A_CMP_HI  = BASE + 32'h4004;
  localparam logic [31:0] A_MT_LO   = BASE + 32'hBFF8;
  localparam logic [31:0] A_MT_HI   = BASE + 32'hBFFC;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ge;
  logic        compress_stall, next_stall_preif, ram_if, ram_mem, load_use, jump, mul_div;
  logic        trap_flush, trap_stall;
  logic [5:0]  stall, flush;

  int vectors     = 0;
  int miscompares = 0;

  clint_timer_pipe_ctrl #(.CLINT_BASE(BASE), .TICK_DIV(1)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mtime_addr_i           (addr),
    .mtime_write_valid_i    (we),
    .mtime_wdata_i          (wdata),
    .mtime_rdata_o          (rdata),
    .mtime_ge_mtime_o       (ge),
    .compress_stall         (compress_stall),
    .next_stall_preif_i     (next_stall_preif),
    .ram_stall_valid_if_i   (ram_if),
    .ram_stall_valid_mem_i  (ram_mem),
    .load_use_valid_id_i    (load_use),
    .jump_valid_ex_i        (jump),
    .alu_mul_div_valid_ex_i (mul_div),
    .trap_flush_valid_wb_i  (trap_flush),
    .trap_stall_valid_wb_i  (trap_stall),
    .stall_o                (stall),
    .flush_o                (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mtime and mtimecmp as plain 64-bit numbers.
  logic [63:0] m_time;
  logic [63:0] m_cmp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_time = 64'd0;
      m_cmp  = {64{1'b1}};
    end else if (we && addr == A_MT_LO) begin
      m_time = {m_time[63:32], wdata};
    end else if (we && addr == A_MT_HI) begin
      m_time = {wdata, m_time[31:0]};
    end else begin
      m_time = m_time + 64'd1;
      if (we && addr == A_CMP_LO) m_cmp = {m_cmp[63:32], wdata};
      if (we && addr == A_CMP_HI) m_cmp = {wdata, m_cmp[31:0]};
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == A_CMP_LO) return m_cmp[31:0];
    if (a == A_CMP_HI) return m_cmp[63:32];
    if (a == A_MT_LO)  return m_time[31:0];
    if (a == A_MT_HI)  return m_time[63:32];
    return 32'h0;
  endfunction

  // Priority table: row i applies when request i is the first one active.
  localparam logic [5:0] ST_TAB [9] = '{6'b000000, 6'b111111, 6'b011111, 6'b001111, 6'b000000,
                                        6'b000111, 6'b000011, 6'b000001, 6'b000000};
  localparam logic [5:0] FL_TAB [9] = '{6'b011111, 6'b000000, 6'b100000, 6'b010000, 6'b000110,
                                        6'b001000, 6'b000100, 6'b000010, 6'b000000};

  function automatic logic [11:0] exp_hazard();
    logic [8:0] req;
    if (!rst) return {6'b000000, 6'b111111};
    req = {1'b1, compress_stall | next_stall_preif, ram_if, load_use, jump, mul_div,
           ram_mem, trap_stall, trap_flush};
    for (int i = 0; i < 9; i++) begin
      if (req[i]) return {ST_TAB[i], FL_TAB[i]};
    end
    return 12'h0;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [11:0] hz;
    hz = exp_hazard();
    check("rdata", {32'h0, rdata}, {32'h0, exp_rdata(addr)});
    check("ge", {63'h0, ge}, {63'h0, (m_time >= m_cmp)});
    check("stall", {58'h0, stall}, {58'h0, hz[11:6]});
    check("flush", {58'h0, flush}, {58'h0, hz[5:0]});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_hazards();
    {compress_stall, next_stall_preif, ram_if, ram_mem, load_use, jump, mul_div,
     trap_flush, trap_stall} = '0;
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0;
    wdata = 32'h0;
    addr = A_MT_LO;
    clear_hazards();
    #1 rst = 1'b0;

    // Reset: held for three clocks.
    repeat (3) step();
    @(negedge clk); #1;
    check("rst_mtime_lo", {32'h0, rdata}, 64'h0);
    addr = A_CMP_LO; #1;
    check("rst_cmp_lo", {32'h0, rdata}, 64'hFFFF_FFFF);
    addr = A_CMP_HI; #1;
    check("rst_cmp_hi", {32'h0, rdata}, 64'hFFFF_FFFF);
    check("rst_ge", {63'h0, ge}, 64'h0);
    check("rst_flush", {58'h0, flush}, 64'h3F);
    check("rst_stall", {58'h0, stall}, 64'h0);
    step();
    rst = 1'b1;
    @(negedge clk); #1;
    check("rel_flush", {58'h0, flush}, 64'h0);

    // Compare: cmp = 20, mtime lo restarted at 0.
    step(); we = 1'b1; addr = A_CMP_LO; wdata = 32'd20;
    step(); addr = A_CMP_HI; wdata = 32'd0;
    step(); addr = A_MT_LO; wdata = 32'd0;
    step(); we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      check("cmp_lo", {32'h0, rdata}, 64'(i));
      check("cmp_ge", {63'h0, ge}, (i >= 20) ? 64'h1 : 64'h0);
      step();
    end

    // Carry from lo into hi.
    we = 1'b1; addr = A_MT_LO; wdata = 32'hFFFF_FFFF;
    step(); we = 1'b0;
    @(negedge clk); #1;
    check("carry_lo0", {32'h0, rdata}, 64'hFFFF_FFFF);
    addr = A_MT_HI; #1;
    check("carry_hi0", {32'h0, rdata}, 64'h0);
    step(); addr = A_MT_LO;
    @(negedge clk); #1;
    check("carry_lo1", {32'h0, rdata}, 64'h0);
    addr = A_MT_HI; #1;
    check("carry_hi1", {32'h0, rdata}, 64'h1);

    // Hazard priority corners.
    step(); trap_flush = 1'b1; ram_mem = 1'b1; load_use = 1'b1;
    @(negedge clk); #1;
    check("trap_stall", {58'h0, stall}, 64'b000000);
    check("trap_flush", {58'h0, flush}, 64'b011111);
    step(); clear_hazards(); load_use = 1'b1;
    @(negedge clk); #1;
    check("lu_stall", {58'h0, stall}, 64'b000111);
    check("lu_flush", {58'h0, flush}, 64'b001000);
    jump = 1'b1; #1;
    check("jmp_stall", {58'h0, stall}, 64'b000000);
    check("jmp_flush", {58'h0, flush}, 64'b000110);
    step(); clear_hazards(); ram_mem = 1'b1; mul_div = 1'b1;
    @(negedge clk); #1;
    check("mem_stall", {58'h0, stall}, 64'b011111);
    check("mem_flush", {58'h0, flush}, 64'b100000);

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 2500; n++) begin
      step();
      if (!rst) begin
        rst = 1'b1;
      end
      {compress_stall, next_stall_preif, ram_if, load_use, jump, mul_div} = '0;
      compress_stall   = ($urandom_range(0, 5) == 0);
      next_stall_preif = ($urandom_range(0, 5) == 0);
      ram_if           = ($urandom_range(0, 4) == 0);
      ram_mem          = ($urandom_range(0, 5) == 0);
      load_use         = ($urandom_range(0, 4) == 0);
      jump             = ($urandom_range(0, 4) == 0);
      mul_div          = ($urandom_range(0, 5) == 0);
      trap_flush       = ($urandom_range(0, 9) == 0);
      trap_stall       = ($urandom_range(0, 9) == 0);
      we               = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: addr = A_CMP_LO;
        1: addr = A_CMP_HI;
        2: addr = A_MT_LO;
        3: addr = A_MT_HI;
        4: addr = BASE + 32'h8;
        5: addr = BASE + 32'hBFF4;
        6: addr = $urandom;
        default: addr = A_MT_LO;
      endcase
      case ($urandom_range(0, 3))
        0, 1: wdata = $urandom_range(0, 40);
        2: wdata = $urandom;
        default: wdata = 32'hFFFF_FFFF;
      endcase
      if (rst && $urandom_range(0, 149) == 0) begin
        #1 rst = 1'b0;
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
